// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax datapath: Q4.12 word width, padding code, collector states.
package softmax_pkg;

   localparam int unsigned DW = 16;
   localparam logic [DW-1:0] NEG_MAX = 16'h8000;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/signed_max2.sv
// Combinational two's-complement maximum of two Q4.12 words; ties return a.
module signed_max2
   import softmax_pkg::*;
(
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] max_c
);

   assign max_c = ($signed(b) > $signed(a)) ? b : a;

endmodule

// File: rtl/softmax_in_buffer.sv
// Serial-to-parallel score collector feeding the softmax stage: gathers up to N words,
// tracks their signed max, pads short vectors with the most-negative code.
module softmax_in_buffer
   import softmax_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DW-1:0]           in_data,
   input  logic                    in_valid,
   input  logic                    in_last,
   output logic                    in_ready,
   output logic [N*DW-1:0]         x_flat,
   output logic [DW-1:0]           max_x,
   output logic [$clog2(N+1)-1:0]  count,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = $clog2(N + 1);

   state_e          state;
   logic [IW-1:0]   idx;
   logic [DW-1:0]   max_q;
   logic [DW-1:0]   lane_q [N];
   logic [DW-1:0]   max_new;
   logic            accept;
   logic            close;

   signed_max2 u_max (
      .a     (max_q),
      .b     (in_data),
      .max_c (max_new)
   );

   assign accept = in_valid & in_ready;
   assign close  = (idx == IW'(N - 1)) | in_last;

   // Collector FSM; handshake flags are flops that track the state so no input reaches them combinationally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_FILL;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         idx       <= '0;
         max_q     <= NEG_MAX;
         count     <= '0;
         for (int i = 0; i < N; i++) lane_q[i] <= '0;
      end else begin
         case (state)
            ST_FILL: begin
               if (accept) begin
                  // Current lane takes the word; on close every higher lane is padded in the same edge.
                  for (int i = 0; i < N; i++) begin
                     if (IW'(i) == idx)
                        lane_q[i] <= in_data;
                     else if (close && (IW'(i) > idx))
                        lane_q[i] <= NEG_MAX;
                  end
                  max_q <= max_new;
                  if (close) begin
                     state     <= ST_HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     count     <= CW'(idx) + CW'(1);
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state     <= ST_FILL;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  idx       <= '0;
                  max_q     <= NEG_MAX;
               end
            end
            default: begin
               state     <= ST_FILL;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign max_x = max_q;

   for (genvar g = 0; g < N; g++) begin : g_flat
      assign x_flat[g*DW +: DW] = lane_q[g];
   end

endmodule

// File: tb/tb_softmax_in_buffer.sv
// Directed bench for softmax_in_buffer (N=8): table of vectors plus backpressure and reset sequences.
module tb_softmax_in_buffer;

   logic         clk;
   logic         rst;
   logic [15:0]  in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [127:0] x_flat;
   logic [15:0]  max_x;
   logic [3:0]   count;
   logic         out_valid;
   logic         out_ready;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0][15:0] d;
      int               len;
      bit               last;
      logic [15:0]      mx;
      logic [3:0]       cnt;
   } vec_t;

   vec_t tv [6];

   softmax_in_buffer #(.N(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .x_flat    (x_flat),
      .max_x     (max_x),
      .count     (count),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [15:0] e0, e1, e2, e3, e4, e5, e6, e7,
                               input int len, input bit last,
                               input logic [15:0] mx, input logic [3:0] cnt);
      vec_t v;
      v.d[0] = e0; v.d[1] = e1; v.d[2] = e2; v.d[3] = e3;
      v.d[4] = e4; v.d[5] = e5; v.d[6] = e6; v.d[7] = e7;
      v.len = len; v.last = last; v.mx = mx; v.cnt = cnt;
      return v;
   endfunction

   function automatic logic [127:0] exp_flat(input vec_t v);
      logic [127:0] f;
      for (int k = 0; k < 8; k++)
         f[k*16 +: 16] = (k < v.len) ? v.d[k] : 16'h8000;
      return f;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      for (int k = 0; k < v.len; k++) begin
         in_valid = 1'b1;
         in_data  = v.d[k];
         in_last  = v.last && (k == v.len - 1);
         chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
         chk({tag, "_ov_low"}, 128'(out_valid), 128'(0));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk({tag, "_out_valid"}, 128'(out_valid), 128'(1));
      chk({tag, "_hold_ready"}, 128'(in_ready), 128'(0));
      chk({tag, "_max"}, 128'(max_x), 128'(v.mx));
      chk({tag, "_count"}, 128'(count), 128'(v.cnt));
      chk({tag, "_lanes"}, x_flat, exp_flat(v));
   endtask

   task automatic handoff(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk({tag, "_ho_ov"}, 128'(out_valid), 128'(0));
      chk({tag, "_ho_ready"}, 128'(in_ready), 128'(1));
   endtask

   initial begin
      tv[0] = mk(16'h1000, 16'hF000, 16'h2800, 16'h0000, 16'h7FFF, 16'h8000, 16'h0400, 16'hE000,
                 8, 1'b0, 16'h7FFF, 4'd8);
      tv[1] = mk(16'hF000, 16'hF100, 16'hF200, 16'hF300, 16'hF400, 16'hF500, 16'hF600, 16'hF700,
                 8, 1'b0, 16'hF700, 4'd8);
      tv[2] = mk(16'h0800, 16'h1800, 16'h0C00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                 3, 1'b1, 16'h1800, 4'd3);
      tv[3] = mk(16'h3000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                 1, 1'b1, 16'h3000, 4'd1);
      tv[4] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                 8, 1'b1, 16'h8000, 4'd8);
      tv[5] = mk(16'hC000, 16'hC000, 16'hC000, 16'hC000, 16'hC000, 16'hC000, 16'hC000, 16'hC000,
                 8, 1'b0, 16'hC000, 4'd8);

      rst = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_ready", 128'(in_ready), 128'(1));
      chk("rst_ov", 128'(out_valid), 128'(0));
      chk("rst_count", 128'(count), 128'(0));
      chk("rst_max", 128'(max_x), 128'h8000);
      chk("rst_lanes", x_flat, 128'(0));
      @(posedge clk); #1;

      // Full vector, then five cycles of backpressure with live input traffic.
      run_vec(tv[0], "full");
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_data  = 16'h7000 + 16'(c);
         in_last  = c[0];
         @(posedge clk); #1;
         chk("bp_ready", 128'(in_ready), 128'(0));
         chk("bp_ov", 128'(out_valid), 128'(1));
         chk("bp_max", 128'(max_x), 128'h7FFF);
         chk("bp_count", 128'(count), 128'(8));
         chk("bp_lanes", x_flat, exp_flat(tv[0]));
      end
      in_last = 1'b0;
      in_data = 16'h7777;
      handoff("bp");
      run_vec(tv[5], "fresh");
      handoff("fresh");

      for (int i = 1; i < 5; i++) begin
         run_vec(tv[i], $sformatf("tv%0d", i));
         handoff($sformatf("tv%0d", i));
      end

      // Async reset after four accepts discards the partial vector.
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_data  = 16'h7000 + 16'(k * 256);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_ready", 128'(in_ready), 128'(1));
      chk("mid_rst_ov", 128'(out_valid), 128'(0));
      chk("mid_rst_count", 128'(count), 128'(0));
      chk("mid_rst_lanes", x_flat, 128'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      run_vec(tv[1], "post_rst");
      handoff("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/softmax_in_buffer.md
# softmax_in_buffer

Serial-to-parallel collector that sits directly upstream of the softmax stage. It accepts Q4.12 scores one per cycle over a valid/ready handshake and stores them into an N-lane vector. It tracks the running signed maximum and presents the completed vector plus its maximum as `x_flat`/`max_x` with a valid/ready handoff. Short vectors, terminated early by `in_last`, are padded with the most-negative code so the padded lanes contribute ≈0 to the softmax sum.

## Interface
- `N`, default 8: vector length (lanes); must be ≥2.
- `clk`  input  1: single clock; all state updates on rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `in_data`  input  16: signed Q4.12 score.
- `in_valid`  input  1: `in_data` is valid.
- `in_last`  input  1: qualifies with `in_valid`; marks the final element of the vector.
- `in_ready`  output  1: buffer accepts input this cycle.
- `x_flat`  output  N*16: lane i at bits [i*16 +: 16]; element i is the i-th accepted word.
- `max_x`  output  16: signed maximum of the accepted elements (padding excluded).
- `count`  output  clog2(N+1): number of real elements in the presented vector (1..N).
- `out_valid`  output  1: `x_flat`/`max_x`/`count` are complete and stable.
- `out_ready`  input  1: consumer takes the vector.

## Operation
- Two states:
  - FILL: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1. Both flags decode from the state register with no combinational path from the inputs.
- Input accept: `in_valid & in_ready`.
- On an accept in FILL:
  - Lane[idx] ← `in_data`; idx increments.
  - max ← signed greater of (max, `in_data`).
  - If idx==N-1 or `in_last`=1 → HOLD. `count` ← idx+1.
- Padding: on the accept that ends a short vector, all lanes above idx are written 0x8000 in the same edge. Lanes are never left stale.
- `in_last` on element N-1 is redundant and harmless. Without `in_last` the vector closes automatically at N elements.
- In HOLD, on `out_ready`=1:
  - → FILL, idx ← 0, max register ← 0x8000.
  - Lanes are not cleared; they are overwritten on refill.
- Outputs in HOLD are frozen until the handoff regardless of `in_valid`/`in_last`.
- Comparison is 16-bit two's complement. Equal values keep the current max, with no observable difference. 0x8000 is a legal input.
- Reset (asynchronous, `rst`=0):
  - State → FILL, idx → 0, max register → 0x8000, `count` → 0, all lanes → 0.
  - `out_valid`=0 and `in_ready`=1 immediately after deassertion.
  - Reset mid-fill or mid-hold discards the partial or pending vector.

## Timing
- Throughput: one element per cycle in FILL; HOLD lasts ≥1 cycle.
- Latency: `out_valid` rises the cycle after the accept of the last element. `max_x` already includes that element.
- Handoff bubble: the cycle after an `out_ready` handoff is FILL. `in_ready` is low during the handoff cycle itself, so no simultaneous accept-and-present occurs.
- Minimum period per N-element vector: N+1 cycles.
- The downstream softmax samples `x_flat`/`max_x` with its `en` driven from `out_valid & out_ready`.

## Structure
- Shared package (`softmax_pkg`):
  - Q4.12 width constant `DW=16`.
  - `NEG_MAX = 16'h8000`.
  - State encoding (`ST_FILL`, `ST_HOLD`).
- One natural sub-module: `signed_max2` (combinational 16-bit signed max), reusable by the downstream add tree.
- Remainder is flat: state flop, idx counter, N lane registers with per-lane write enable (write on idx match, or pad on close).

## Test plan
- N=8, inputs 0x1000,0xF000,0x2800,0x0000,0x7FFF,0x8000,0x0400,0xE000 back-to-back, `out_ready`=1:
  - `out_valid` rises 1 cycle after the 8th accept.
  - `max_x`=0x7FFF, `count`=8, lanes in order.
- All negative (0xF000..0xF700 ascending) → `max_x`=0xF700, verifying signed compare and that the 0x8000 initial max never survives.
- Short vector 0x0800,0x1800,0x0C00 with `in_last` on the third → `count`=3, `max_x`=0x1800, lanes 3..7 = 0x8000.
- Backpressure: `out_ready`=0 for 5 cycles in HOLD with `in_valid`=1 toggling data:
  - `in_ready`=0 throughout; outputs unchanged.
  - After the handoff, the next vector's max is computed fresh (e.g. all 0xC000 → `max_x`=0xC000).
- Asynchronous reset asserted after 4 accepts:
  - `in_ready`=1, `out_valid`=0, `count`=0 immediately.
  - A following full 8-element vector produces the correct max with no stale lanes.
- `in_last` on the very first element (0x3000) → `count`=1, `max_x`=0x3000, lanes 1..7 = 0x8000.
